axi_burst_slave: RTL and testbench
==================================

AXI_BURST_SLAVE -- requirements
Module: axi_burst_slave

Interface
REQ-001 Parameter AXI_DW, default 64: data width (32, 64, 128).
REQ-002 Parameter AXI_AW, default 32: address width.
REQ-003 Parameter AXI_IW, default 8: ID width.
REQ-004 Parameter TMO_W, default 5: timeout counter width; a beat times out after 2^TMO_W cycles.
REQ-005 axi_clk_i  in  1: the single clock.
REQ-006 axi_rstn_i  in  1: reset; asynchronous, active-low.
REQ-007 AW group, SHALL be: axi_awid_i in AXI_IW, axi_awaddr_i in AXI_AW, axi_awlen_i in 4, axi_awsize_i in 3, axi_awburst_i in 2, axi_awvalid_i in 1, axi_awready_o out 1.
REQ-008 W group, SHALL be: axi_wdata_i in AXI_DW, axi_wstrb_i in AXI_DW/8, axi_wlast_i in 1, axi_wvalid_i in 1, axi_wready_o out 1.
REQ-009 B group, SHALL be: axi_bid_o out AXI_IW, axi_bresp_o out 2, axi_bvalid_o out 1, axi_bready_i in 1.
REQ-010 AR group, SHALL be: axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i, axi_arvalid_i, axi_arready_o, with widths as in AW.
REQ-011 R group, SHALL be: axi_rid_o out AXI_IW, axi_rdata_o out AXI_DW, axi_rresp_o out 2, axi_rlast_o out 1, axi_rvalid_o out 1, axi_rready_i in 1.
REQ-012 Sys group, SHALL be: sys_addr_o out AXI_AW, sys_wdata_o out AXI_DW, sys_sel_o out AXI_DW/8, sys_wen_o out 1, sys_ren_o out 1, sys_rdata_i in AXI_DW, sys_err_i in 1, sys_ack_i in 1.

Function
REQ-013 The FSM SHALL have states IDLE, WR_DATA, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT and RD_DATA.
REQ-014 axi_awready_o SHALL equal (state==IDLE); axi_arready_o SHALL equal (state==IDLE && !axi_awvalid_i). Write wins a simultaneous request.
REQ-015 On an address handshake, the block SHALL latch id, addr, len, size and burst, and load the beat counter with len (1..16 beats).
REQ-016 A request SHALL be marked bad when size != log2(AXI_DW/8), or burst is WRAP or reserved. A bad request SHALL consume all beats, issue no sys strobes, and respond SLVERR on every beat.
REQ-017 In WR_DATA, axi_wready_o SHALL be 1. A W handshake SHALL produce, on the next cycle, a 1-cycle sys_wen_o with sys_wdata_o=wdata and sys_sel_o=wstrb, then move to WR_WAIT.
REQ-018 WR_WAIT SHALL exit on sys_ack_i, on timeout, or immediately when the request is bad. Exit goes to WR_RESP on the final beat, otherwise to WR_DATA with the next address.
REQ-019 Next address SHALL be addr + AXI_DW/8 for INCR (modulo 2^AXI_AW) and unchanged for FIXED.
REQ-020 axi_wlast_i mismatching the final-beat position SHALL set sticky SLVERR. Beat count follows len regardless.
REQ-021 bresp SHALL be SLVERR if any beat was bad, timed out, errored (sys_err_i with ack) or had a wlast mismatch; otherwise OKAY. bvalid SHALL be held until bready; then the FSM returns to IDLE.
REQ-022 RD_REQ SHALL issue a 1-cycle sys_ren_o at the current address. RD_WAIT SHALL capture sys_rdata_i on ack; on timeout or bad request it SHALL capture data 0.
REQ-023 RD_DATA SHALL hold rvalid, rdata and per-beat rresp until rready. rlast SHALL be 1 only on the final beat. Then the FSM goes to RD_REQ or IDLE.
REQ-024 The timeout counter SHALL restart at each sys strobe. Expiry SHALL count as ack with SLVERR.
REQ-025 Minimum latency SHALL be: W handshake to sys_wen_o 1 cycle; ack to next wready 1 cycle; ack to rvalid 1 cycle.
REQ-026 axi_bid_o and axi_rid_o SHALL present the latched id of the active transaction.

Reset
REQ-027 Asserting axi_rstn_i low, including mid-burst, SHALL immediately force IDLE and drop the in-flight transaction.
REQ-028 During reset, all valid, ready and strobe outputs SHALL be 0, resp outputs 2'b00, rlast 0, sys_sel_o 0, and address/data registers 0.

Structure
REQ-029 Package axi_burst_pkg SHALL hold the FSM state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and BURST_FIXED/INCR/WRAP constants.
REQ-030 Next-address arithmetic SHALL live in sub-module axi_burst_addr_gen, parameterised by AXI_AW and AXI_DW.

Verification
REQ-031 INCR write, addr 0x1000, len 3, size 3, all acks after 2 cycles -> sys_wen at 0x1000/08/10/18 with matching strobes, bresp OKAY.
REQ-032 INCR read, len 1, sys_rdata 0xA then 0xB, rready stalled 3 cycles on beat 0 -> rdata held stable, rlast only on beat 1, rresp OKAY.
REQ-033 Write with no sys_ack_i, TMO_W=5 -> bresp SLVERR 32 cycles after sys_wen; the next transaction is accepted normally.
REQ-034 Same-cycle awvalid and arvalid -> write served first, arready 0 until write completes, then read served.
REQ-035 WRAP read len 3 -> no sys_ren, 4 beats with rresp SLVERR and rdata 0, rlast on beat 3.
REQ-036 axi_rstn_i pulsed low during beat 2 of a len-7 write -> outputs go to reset values immediately; a fresh write after release completes OKAY.

Source files
------------

// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI burst slave: FSM states, response
// codes, burst encodings and the request legality check.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrData = 3'd1,
    StWrWait = 3'd2,
    StWrResp = 3'd3,
    StRdReq  = 3'd4,
    StRdWait = 3'd5,
    StRdData = 3'd6
  } axi_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Only full-width beats with FIXED or INCR bursts reach the system bus.
  function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [2:0] full_size);
    return (size != full_size) || (burst == BURST_WRAP) || (burst == 2'b11);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Beat-to-beat address step: INCR advances by one bus word, FIXED holds.
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned AXI_DW = 64
) (
  input  logic [AXI_AW-1:0] addr_i,
  input  logic [1:0]        burst_i,
  output logic [AXI_AW-1:0] next_addr_o
);

  localparam logic [AXI_AW-1:0] Step = AXI_AW'(AXI_DW / 8);

  always_comb begin
    next_addr_o = addr_i;
    if (burst_i == BURST_INCR) begin
      next_addr_o = addr_i + Step;
    end
  end

endmodule

// File: rtl/axi_burst_slave.sv
// AXI3-style burst slave bridging one transaction at a time onto a simple
// strobed system bus with ack/err handshake and a per-beat timeout.
module axi_burst_slave
  import axi_burst_pkg::*;
#(
  parameter int unsigned AXI_DW = 64,
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned AXI_IW = 8,
  parameter int unsigned TMO_W  = 5
) (
  input  logic                  axi_clk_i,
  input  logic                  axi_rstn_i,
  // AW
  input  logic [AXI_IW-1:0]     axi_awid_i,
  input  logic [AXI_AW-1:0]     axi_awaddr_i,
  input  logic [3:0]            axi_awlen_i,
  input  logic [2:0]            axi_awsize_i,
  input  logic [1:0]            axi_awburst_i,
  input  logic                  axi_awvalid_i,
  output logic                  axi_awready_o,
  // W
  input  logic [AXI_DW-1:0]     axi_wdata_i,
  input  logic [AXI_DW/8-1:0]   axi_wstrb_i,
  input  logic                  axi_wlast_i,
  input  logic                  axi_wvalid_i,
  output logic                  axi_wready_o,
  // B
  output logic [AXI_IW-1:0]     axi_bid_o,
  output logic [1:0]            axi_bresp_o,
  output logic                  axi_bvalid_o,
  input  logic                  axi_bready_i,
  // AR
  input  logic [AXI_IW-1:0]     axi_arid_i,
  input  logic [AXI_AW-1:0]     axi_araddr_i,
  input  logic [3:0]            axi_arlen_i,
  input  logic [2:0]            axi_arsize_i,
  input  logic [1:0]            axi_arburst_i,
  input  logic                  axi_arvalid_i,
  output logic                  axi_arready_o,
  // R
  output logic [AXI_IW-1:0]     axi_rid_o,
  output logic [AXI_DW-1:0]     axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic                  axi_rlast_o,
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  // System bus
  output logic [AXI_AW-1:0]     sys_addr_o,
  output logic [AXI_DW-1:0]     sys_wdata_o,
  output logic [AXI_DW/8-1:0]   sys_sel_o,
  output logic                  sys_wen_o,
  output logic                  sys_ren_o,
  input  logic [AXI_DW-1:0]     sys_rdata_i,
  input  logic                  sys_err_i,
  input  logic                  sys_ack_i
);

  localparam int unsigned SW       = AXI_DW / 8;
  localparam logic [2:0]  FullSize = 3'($clog2(SW));

  axi_state_e          state_q, state_d;
  logic                live_q;
  logic [AXI_IW-1:0]   id_q, id_d;
  logic [AXI_AW-1:0]   addr_q, addr_d, next_addr;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          burst_q, burst_d;
  logic                bad_q, bad_d;
  logic                err_q, err_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [AXI_DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                wen_q, wen_d;
  logic [AXI_DW-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                tmo_exp, last_beat;

  assign tmo_exp   = (tmo_q == {TMO_W{1'b1}});
  assign last_beat = (cnt_q == 4'd0);

  axi_burst_addr_gen #(
    .AXI_AW (AXI_AW),
    .AXI_DW (AXI_DW)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    bad_d   = bad_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    wen_d   = 1'b0;
    rdata_d = rdata_q;
    rresp_d = rresp_q;

    case (state_q)
      StIdle: begin
        if (live_q && axi_awvalid_i) begin
          id_d    = axi_awid_i;
          addr_d  = axi_awaddr_i;
          cnt_d   = axi_awlen_i;
          burst_d = axi_awburst_i;
          bad_d   = req_bad(axi_awsize_i, axi_awburst_i, FullSize);
          err_d   = 1'b0;
          state_d = StWrData;
        end else if (live_q && axi_arvalid_i) begin
          id_d    = axi_arid_i;
          addr_d  = axi_araddr_i;
          cnt_d   = axi_arlen_i;
          burst_d = axi_arburst_i;
          bad_d   = req_bad(axi_arsize_i, axi_arburst_i, FullSize);
          state_d = StRdReq;
        end
      end
      StWrData: begin
        if (axi_wvalid_i) begin
          wdata_d = axi_wdata_i;
          sel_d   = axi_wstrb_i;
          wen_d   = !bad_q;
          tmo_d   = '0;
          if (axi_wlast_i != last_beat) err_d = 1'b1;
          state_d = StWrWait;
        end
      end
      StWrWait: begin
        if (bad_q || sys_ack_i || tmo_exp) begin
          if (bad_q || (sys_ack_i ? sys_err_i : tmo_exp)) err_d = 1'b1;
          if (last_beat) begin
            state_d = StWrResp;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            addr_d  = next_addr;
            state_d = StWrData;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWrResp: begin
        if (axi_bready_i) state_d = StIdle;
      end
      StRdReq: begin
        tmo_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (bad_q || (!sys_ack_i && tmo_exp)) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          state_d = StRdData;
        end else if (sys_ack_i) begin
          rdata_d = sys_rdata_i;
          rresp_d = sys_err_i ? RESP_SLVERR : RESP_OKAY;
          state_d = StRdData;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRdData: begin
        if (axi_rready_i) begin
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            addr_d  = next_addr;
            state_d = StRdReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // live_q keeps the ready outputs low until the first clock after reset release.
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q <= StIdle;
      live_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      bad_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      id_q    <= id_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign axi_awready_o = live_q && (state_q == StIdle);
  assign axi_arready_o = live_q && (state_q == StIdle) && !axi_awvalid_i;
  assign axi_wready_o  = (state_q == StWrData);
  assign axi_bvalid_o  = (state_q == StWrResp);
  assign axi_bresp_o   = (axi_bvalid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi_bid_o     = id_q;
  assign axi_rvalid_o  = (state_q == StRdData);
  assign axi_rdata_o   = rdata_q;
  assign axi_rresp_o   = axi_rvalid_o ? rresp_q : RESP_OKAY;
  assign axi_rlast_o   = axi_rvalid_o && last_beat;
  assign axi_rid_o     = id_q;

  assign sys_addr_o  = addr_q;
  assign sys_wdata_o = wdata_q;
  assign sys_sel_o   = sel_q;
  assign sys_wen_o   = wen_q;
  assign sys_ren_o   = (state_q == StRdReq) && !bad_q;

endmodule

// File: tb/tb_axi_burst_slave.sv
// Directed scoreboard bench for axi_burst_slave with a simple ack-delay
// system-bus responder; everything runs in one initial block.
module tb_axi_burst_slave;
  import axi_burst_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, sys_addr;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [63:0] wdata, rdata, sys_wdata, sys_rdata;
  logic [7:0]  wstrb, sys_sel;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic        sys_wen, sys_ren, sys_err, sys_ack;

  typedef struct packed {logic [31:0] addr; logic [63:0] data; logic [7:0] sel;} wr_t;
  typedef struct packed {logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last;} rd_t;
  typedef struct packed {logic [7:0] id; logic [1:0] resp;} b_t;

  wr_t         exp_w[$];
  rd_t         exp_r[$];
  b_t          exp_b[$];
  logic [31:0] exp_ra[$];
  logic [63:0] rd_q[$];

  int n_cmp = 0, n_bad = 0, cyc = 0, wen_cyc = 0;
  int ack_dly = 2, ack_cnt = 0, r_stall = 0, r_stall_cfg = 0;
  bit ack_en = 1, ack_pend = 0, chk_tmo = 0, r_busy = 0;
  logic [63:0] rd_hold = '0;

  always #5 clk = ~clk;

  axi_burst_slave #(.AXI_DW(64), .AXI_AW(32), .AXI_IW(8), .TMO_W(5)) dut (
    .axi_clk_i(clk), .axi_rstn_i(rstn),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
    .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
    .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
    .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .sys_addr_o(sys_addr), .sys_wdata_o(sys_wdata), .sys_sel_o(sys_sel), .sys_wen_o(sys_wen),
    .sys_ren_o(sys_ren), .sys_rdata_i(sys_rdata), .sys_err_i(sys_err), .sys_ack_i(sys_ack)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strb_of(input int b);
    case (b % 4)
      0:       return 8'hFF;
      1:       return 8'h0F;
      2:       return 8'hF0;
      default: return 8'h3C;
    endcase
  endfunction

  // One clock: sample 1 time unit after the edge, run the responder and scoreboards.
  task automatic step();
    wr_t w;
    @(posedge clk);
    #1;
    cyc++;
    sys_ack = 1'b0;
    if (ack_pend) begin
      if (ack_cnt == 0) begin
        sys_ack = 1'b1; sys_rdata = rd_hold; ack_pend = 0;
      end else ack_cnt--;
    end
    if (sys_wen) begin
      wen_cyc = cyc;
      if (exp_w.size() == 0) check("unexpected_wen", 128'(sys_wen), 128'(0));
      else begin
        w = exp_w.pop_front();
        check("wen_beat", 128'({sys_addr, sys_wdata, sys_sel}), 128'(w));
      end
      if (ack_en) begin ack_pend = 1; ack_cnt = ack_dly; end
    end
    if (sys_ren) begin
      if (exp_ra.size() == 0) check("unexpected_ren", 128'(sys_ren), 128'(0));
      else check("ren_addr", 128'(sys_addr), 128'(exp_ra.pop_front()));
      rd_hold = (rd_q.size() != 0) ? rd_q.pop_front() : 64'h0;
      if (ack_en) begin ack_pend = 1; ack_cnt = ack_dly; end
    end
    if (bvalid) begin
      if (exp_b.size() == 0) check("unexpected_b", 128'(bvalid), 128'(0));
      else check("bresp", 128'({bid, bresp}), 128'(exp_b.pop_front()));
      if (chk_tmo) check("tmo_latency", 128'(cyc - wen_cyc), 128'(32));
    end
    if (rvalid) begin
      if (!r_busy) begin r_busy = 1; r_stall = r_stall_cfg; r_stall_cfg = 0; end
      if (exp_r.size() == 0) begin
        check("unexpected_r", 128'(rvalid), 128'(0));
        rready = 1'b1; r_busy = 0;
      end else if (r_stall > 0) begin
        check("rdata_held", 128'(rdata), 128'(exp_r[0].data));
        r_stall--; rready = 1'b0;
      end else begin
        check("rbeat", 128'({rid, rdata, rresp, rlast}), 128'(exp_r.pop_front()));
        rready = 1'b1; r_busy = 0;
      end
    end else rready = 1'b0;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 200) begin step(); n++; end
    check("aw_handshake", 128'(awready), 128'(1));
    step();
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = a; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 200) begin step(); n++; end
    check("ar_handshake", 128'(arready), 128'(1));
    step();
    arvalid = 1'b0;
  endtask

  task automatic w_send(input logic [3:0] len, input int nbeats, input logic [31:0] a0,
                        input logic [1:0] burst, input logic [7:0] seed);
    logic [31:0] a = a0;
    for (int b = 0; b < nbeats; b++) begin
      int n = 0;
      wdata = {seed, 24'hC0FFEE, 32'(b)};
      wstrb = strb_of(b);
      wlast = (b == int'(len));
      exp_w.push_back({a, wdata, wstrb});
      wvalid = 1'b1;
      while (!wready && n < 200) begin step(); n++; end
      check("w_handshake", 128'(wready), 128'(1));
      step();
      wvalid = 1'b0; wlast = 1'b0;
      if (burst == BURST_INCR) a = a + 32'd8;
    end
  endtask

  task automatic wait_b();
    int n = 0;
    while (exp_b.size() != 0 && n < 300) begin step(); n++; end
    check("b_received", 128'(exp_b.size()), 128'(0));
  endtask

  task automatic wait_r();
    int n = 0;
    while (exp_r.size() != 0 && n < 400) begin step(); n++; end
    check("r_received", 128'(exp_r.size()), 128'(0));
  endtask

  initial begin
    rstn = 1'b0;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid} = '0;
    {wdata, wstrb, wlast, wvalid} = '0;
    bready = 1'b1; rready = 1'b0;
    sys_rdata = '0; sys_err = 1'b0; sys_ack = 1'b0;

    #23;
    check("rst_ready", 128'({awready, arready, wready}), 128'(0));
    check("rst_valid", 128'({bvalid, rvalid, rlast}), 128'(0));
    check("rst_strobe", 128'({sys_wen, sys_ren, sys_sel}), 128'(0));
    check("rst_resp", 128'({bresp, rresp}), 128'(0));
    check("rst_addr_data", 128'({sys_addr, sys_wdata}), 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    #4 rstn = 1'b1;
    step();
    check("idle_ready", 128'({awready, arready}), 128'(2'b11));

    // INCR write, 4 beats
    exp_b.push_back({8'h11, RESP_OKAY});
    aw_send(8'h11, 32'h1000, 4'd3, BURST_INCR);
    w_send(4'd3, 4, 32'h1000, BURST_INCR, 8'hA1);
    wait_b();

    // INCR read, 2 beats, first beat stalled
    rd_q.push_back(64'hA); rd_q.push_back(64'hB);
    exp_ra.push_back(32'h3000); exp_ra.push_back(32'h3008);
    exp_r.push_back({8'h22, 64'hA, RESP_OKAY, 1'b0});
    exp_r.push_back({8'h22, 64'hB, RESP_OKAY, 1'b1});
    r_stall_cfg = 3;
    ar_send(8'h22, 32'h3000, 4'd1, BURST_INCR);
    wait_r();

    // Write with no ack: timeout then a normal FIXED write
    ack_en = 0; chk_tmo = 1;
    exp_b.push_back({8'h33, RESP_SLVERR});
    aw_send(8'h33, 32'h4000, 4'd0, BURST_INCR);
    w_send(4'd0, 1, 32'h4000, BURST_INCR, 8'hB3);
    wait_b();
    ack_en = 1; chk_tmo = 0;
    exp_b.push_back({8'h34, RESP_OKAY});
    aw_send(8'h34, 32'h2000, 4'd1, BURST_FIXED);
    w_send(4'd1, 2, 32'h2000, BURST_FIXED, 8'hC4);
    wait_b();

    // Simultaneous AW/AR: write first, read held off
    arid = 8'h45; araddr = 32'h5000; arlen = 4'd0; arsize = 3'd3; arburst = BURST_INCR;
    arvalid = 1'b1;
    exp_b.push_back({8'h44, RESP_OKAY});
    aw_send(8'h44, 32'h6000, 4'd1, BURST_INCR);
    check("ar_blocked_aw", 128'(arready), 128'(0));
    w_send(4'd1, 2, 32'h6000, BURST_INCR, 8'hD4);
    check("ar_blocked_w", 128'(arready), 128'(0));
    wait_b();
    rd_q.push_back(64'h55); exp_ra.push_back(32'h5000);
    exp_r.push_back({8'h45, 64'h55, RESP_OKAY, 1'b1});
    ar_send(8'h45, 32'h5000, 4'd0, BURST_INCR);
    wait_r();

    // WRAP read: rejected beat by beat, no sys reads
    for (int b = 0; b < 4; b++) exp_r.push_back({8'h66, 64'h0, RESP_SLVERR, b == 3});
    ar_send(8'h66, 32'h7000, 4'd3, BURST_WRAP);
    wait_r();

    // Reset pulse during beat 2 of a len-7 write
    aw_send(8'h77, 32'h8000, 4'd7, BURST_INCR);
    w_send(4'd7, 2, 32'h8000, BURST_INCR, 8'hE7);
    wvalid = 1'b1;
    begin
      int n = 0;
      while (!wready && n < 200) begin step(); n++; end
    end
    rstn = 1'b0;
    #1;
    check("midrst_ready", 128'({awready, arready, wready}), 128'(0));
    check("midrst_valid", 128'({bvalid, rvalid, sys_wen, sys_ren}), 128'(0));
    check("midrst_regs", 128'({sys_addr, sys_wdata, sys_sel}), 128'(0));
    wvalid = 1'b0;
    exp_w.delete(); exp_b.delete(); ack_pend = 0;
    step(); step();
    rstn = 1'b1;
    step();
    exp_b.push_back({8'h78, RESP_OKAY});
    aw_send(8'h78, 32'h9000, 4'd1, BURST_INCR);
    w_send(4'd1, 2, 32'h9000, BURST_INCR, 8'hF8);
    wait_b();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
